// File: rtl/serial_tx_pkg.sv
// Shared constants for the serial link blocks: FSM state codes and parameter defaults.
// MIN_CLKS_PER_BIT is the shortest legal bit period that still clears the far-end sync + filter.
package serial_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int MIN_CLKS_PER_BIT = 8;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle of each bit.
// Held at zero while clear is high so the first bit after a clear is a full period.
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, DATA_BITS payload LSB first, STOP_BITS stop bits.
// tx, ready and busy all come straight from flops so the line never glitches.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (valid && ready_q) begin
                    shreg_d = data_in;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d      = shreg_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // Next bit is read from shreg_q[1] because the shift lands on this same edge.
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        tx_d       = 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = ST_STOP;
                    end else begin
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: an 8N1 instance and a 7-data/2-stop instance at the minimum bit period,
// with a receiver-side sync + 3-count filter model used for loopback decoding.
module tb_serial_tx;
    import serial_tx_pkg::*;

    localparam int N = MIN_CLKS_PER_BIT;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d1;
    logic       v1, rdy1, tx1, busy1;
    logic [6:0] d2;
    logic       v2, rdy2, tx2, busy2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    serial_tx #(.CLKS_PER_BIT(N), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .data_in(d1), .valid(v1),
        .ready(rdy1), .tx(tx1), .busy(busy1)
    );

    serial_tx #(.CLKS_PER_BIT(N), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(d2), .valid(v2),
        .ready(rdy2), .tx(tx2), .busy(busy2)
    );

    // Far-end line conditioning: 2-flop synchronizer, then a filter that only follows
    // a new level after three consecutive agreeing samples.
    logic s1 = 1'b1, s2 = 1'b1, filt = 1'b1, filt_d = 1'b1;
    int   fcnt = 0;
    int   run = 1000;
    int   spikes = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) begin
        s1 <= tx1;
        s2 <= s1;
        if (s2 !== filt && (s2 === 1'b0 || s2 === 1'b1)) begin
            if (fcnt == 2) begin
                filt <= s2;
                fcnt <= 0;
            end else begin
                fcnt <= fcnt + 1;
            end
        end else begin
            fcnt <= 0;
        end
        filt_d <= filt;
        if (filt !== filt_d) begin
            if (mon_en && run < N) spikes <= spikes + 1;
            run <= 1;
        end else begin
            run <= run + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level c clocks after the accept edge, straight from the frame layout.
    function automatic logic exp_tx(input logic [8:0] w, input int dbits, input int c);
        int pos;
        pos = c / N;
        if (pos == 0) return 1'b0;
        if (pos <= dbits) return w[pos-1];
        return 1'b1;
    endfunction

    // Called right after the accept edge; follows the whole frame and the ready-reassert edge.
    task automatic expect_frame(input bit sel, input logic [8:0] w, input int dbits,
                                input int sbits, input bit disturb, input string tag);
        int flen;
        logic t, r, b;
        flen = (1 + dbits + sbits) * N;
        for (int c = 0; c < flen; c++) begin
            t = sel ? tx2 : tx1;
            r = sel ? rdy2 : rdy1;
            b = sel ? busy2 : busy1;
            vectors++;
            if (t !== exp_tx(w, dbits, c)) begin
                errors++;
                $display("FAIL %s tx c=%0d got %b want %b", tag, c, t, exp_tx(w, dbits, c));
            end
            vectors++;
            if ({r, b} !== 2'b01) begin
                errors++;
                $display("FAIL %s ready/busy c=%0d got %b%b want 01", tag, c, r, b);
            end
            if (disturb) begin
                d1 = 8'($urandom);
                v1 = (c < flen - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            step();
        end
        t = sel ? tx2 : tx1;
        r = sel ? rdy2 : rdy1;
        b = sel ? busy2 : busy1;
        vectors++;
        if ({t, r, b} !== 3'b110) begin
            errors++;
            $display("FAIL %s end-of-frame tx/ready/busy got %b%b%b want 110 after %0d clocks",
                     tag, t, r, b, flen);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v1 = 1'b1; d1 = 8'h5A;
        v2 = 1'b1; d2 = 7'h11;
        repeat (3) step();
        vectors++;
        if ({tx1, rdy1, busy1} !== 3'b110) begin
            errors++;
            $display("FAIL reset dut1 tx/ready/busy got %b%b%b want 110", tx1, rdy1, busy1);
        end
        vectors++;
        if ({tx2, rdy2, busy2} !== 3'b110) begin
            errors++;
            $display("FAIL reset dut2 tx/ready/busy got %b%b%b want 110", tx2, rdy2, busy2);
        end
        reset = 1'b0; v1 = 1'b0; v2 = 1'b0;
        step();
        vectors++;
        if ({tx1, rdy1, tx2, rdy2} !== 4'b1111) begin
            errors++;
            $display("FAIL post_reset idle got %b%b%b%b want 1111", tx1, rdy1, tx2, rdy2);
        end
    endtask

    task automatic test_basic();
        d1 = 8'hA5; v1 = 1'b1;
        step();
        v1 = 1'b0;
        expect_frame(1'b0, 9'h0A5, 8, 1, 1'b0, "basic_a5");
    endtask

    task automatic test_random_frames();
        logic [7:0] w;
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) step();
            d1 = w; v1 = 1'b1;
            step();
            v1 = 1'b0;
            expect_frame(1'b0, {1'b0, w}, 8, 1, 1'b1, "random_ignore");
            v1 = 1'b0;
            step();
            vectors++;
            if ({tx1, rdy1} !== 2'b11) begin
                errors++;
                $display("FAIL no_requeue got tx/ready %b%b want 11", tx1, rdy1);
            end
        end
    endtask

    task automatic test_back_to_back();
        d1 = 8'h01; v1 = 1'b1;
        step();
        d1 = 8'h80;
        expect_frame(1'b0, 9'h001, 8, 1, 1'b0, "b2b_first");
        step();
        v1 = 1'b0;
        expect_frame(1'b0, 9'h080, 8, 1, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'($urandom);
        d1 = w; v1 = 1'b1;
        step();
        v1 = 1'b0;
        repeat (4 * N + 3) step();
        vectors++;
        if (tx1 !== w[3]) begin
            errors++;
            $display("FAIL reset_mid bit3 got %b want %b", tx1, w[3]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({tx1, rdy1, busy1} !== 3'b110) begin
            errors++;
            $display("FAIL reset_mid recover tx/ready/busy got %b%b%b want 110", tx1, rdy1, busy1);
        end
        d1 = 8'hC3; v1 = 1'b1;
        step();
        v1 = 1'b0;
        expect_frame(1'b0, 9'h0C3, 8, 1, 1'b0, "after_reset_c3");
    endtask

    task automatic test_stop2();
        logic [6:0] w;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 7'h41 : 7'($urandom);
            d2 = w; v2 = 1'b1;
            step();
            v2 = 1'b0;
            expect_frame(1'b1, {2'b00, w}, 7, 2, 1'b0, "stop2");
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words[5];
        logic [7:0] got[$];
        int spikes0;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
        words[3] = 8'($urandom); words[4] = 8'($urandom);
        spikes0 = spikes;
        mon_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    int g;
                    d1 = words[k]; v1 = 1'b1;
                    g = 0;
                    do begin step(); g++; end while (rdy1 !== 1'b0 && g < 30 * N);
                    v1 = 1'b0;
                    g = 0;
                    while (rdy1 !== 1'b1 && g < 30 * N) begin step(); g++; end
                    if (g >= 30 * N) begin
                        vectors++; errors++;
                        $display("FAIL loopback sender timeout word %0d", k);
                        break;
                    end
                end
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    int g;
                    logic [7:0] rx;
                    g = 0;
                    while (filt !== 1'b0 && g < 40 * N) begin step(); g++; end
                    if (g >= 40 * N) begin
                        vectors++; errors++;
                        $display("FAIL loopback start-bit timeout word %0d", k);
                        break;
                    end
                    repeat (N / 2) step();
                    for (int b = 0; b < 8; b++) begin
                        repeat (N) step();
                        rx[b] = filt;
                    end
                    repeat (N) step();
                    vectors++;
                    if (filt !== 1'b1) begin
                        errors++;
                        $display("FAIL loopback stop word %0d got %b want 1", k, filt);
                    end
                    got.push_back(rx);
                end
            end
        join
        repeat (4 * N) step();
        mon_en = 1'b0;
        vectors++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL loopback count got %0d want 5", got.size());
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            vectors++;
            if (got[k] !== words[k]) begin
                errors++;
                $display("FAIL loopback word %0d got %h want %h", k, got[k], words[k]);
            end
        end
        vectors++;
        if (spikes != spikes0) begin
            errors++;
            $display("FAIL loopback spikes got %0d want 0", spikes - spikes0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random_frames();
        test_back_to_back();
        test_reset_mid();
        test_stop2();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
